icap_multiboot_seq: RTL and testbench

ICAP_MULTIBOOT_SEQ -- requirements
Module: icap_multiboot_seq

---
 rtl/icap_multiboot_seq.sv | 132 +++++++++++++
 tb/tb_icap_multiboot_seq.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icap_multiboot_seq.sv
// rtl/icap_multiboot_seq.sv - Wishbone master issuing the ICAP IPROG multiboot word sequence
module icap_multiboot_seq #(
   parameter logic [7:0]  SPI_RD_OPCODE = 8'h0B,
   parameter int unsigned ACK_TIMEOUT   = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [23:0] boot_addr,
   input  logic [23:0] golden_addr,
   output logic        cyc_o,
   output logic        stb_o,
   output logic        we_o,
   output logic [31:0] dat_o,
   input  logic        ack_i,
   output logic        busy,
   output logic        done,
   output logic        error
);

   // Last ack-less WRITE cycle that is still allowed before giving up on the word.
   localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);
   localparam logic [3:0] LAST_INDEX   = 4'd13;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_GAP,
      S_DONE,
      S_FAULT
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        accept;
   logic [3:0]  index;
   logic [7:0]  tcnt;
   logic [23:0] boot_q;
   logic [23:0] golden_q;
   logic [15:0] word;

   // State register; reset abandons any sequence in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; ack beats the timeout when both land on the same cycle.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_FAULT: begin
            if (start) begin
               accept     = 1'b1;
               state_next = S_WRITE;
            end
         end
         S_WRITE: begin
            if (ack_i) begin
               state_next = (index == LAST_INDEX) ? S_DONE : S_GAP;
            end else if (tcnt == TIMEOUT_LAST) begin
               state_next = S_FAULT;
            end
         end
         S_GAP: begin
            state_next = S_WRITE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Word index, per-word ack timeout counter and the addresses captured at start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         index    <= 4'd0;
         tcnt     <= 8'd0;
         boot_q   <= 24'd0;
         golden_q <= 24'd0;
      end else if (accept) begin
         index    <= 4'd0;
         tcnt     <= 8'd0;
         boot_q   <= boot_addr;
         golden_q <= golden_addr;
      end else if (state == S_WRITE) begin
         if (ack_i) begin
            tcnt <= 8'd0;
            if (index != LAST_INDEX) begin
               index <= index + 4'd1;
            end
         end else begin
            tcnt <= tcnt + 8'd1;
         end
      end
   end

   // IPROG word table: sync, address/opcode registers, IPROG command, NOOP.
   always_comb begin
      word = 16'h0000;
      case (index)
         4'd0:    word = 16'hFFFF;
         4'd1:    word = 16'hAA99;
         4'd2:    word = 16'h5566;
         4'd3:    word = 16'h3261;
         4'd4:    word = boot_q[15:0];
         4'd5:    word = 16'h3281;
         4'd6:    word = {SPI_RD_OPCODE, boot_q[23:16]};
         4'd7:    word = 16'h32A1;
         4'd8:    word = golden_q[15:0];
         4'd9:    word = 16'h32C1;
         4'd10:   word = {SPI_RD_OPCODE, golden_q[23:16]};
         4'd11:   word = 16'h30A1;
         4'd12:   word = 16'h000E;
         4'd13:   word = 16'h2000;
         default: word = 16'h0000;
      endcase
   end

   assign cyc_o = (state == S_WRITE);
   assign stb_o = (state == S_WRITE);
   assign we_o  = (state == S_WRITE);
   assign dat_o = {16'h0000, (state == S_WRITE) ? word : 16'h0000};
   assign busy  = (state == S_WRITE) || (state == S_GAP);
   assign done  = (state == S_DONE);
   assign error = (state == S_FAULT);

endmodule

// File: tb/tb_icap_multiboot_seq.sv
// tb/tb_icap_multiboot_seq.sv - self-checking bench for icap_multiboot_seq
module tb_icap_multiboot_seq;

   localparam int TMO = 255;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [23:0] boot_addr;
   logic [23:0] golden_addr;
   logic        cyc_o;
   logic        stb_o;
   logic        we_o;
   logic [31:0] dat_o;
   logic        ack_i;
   logic        busy;
   logic        done;
   logic        error;

   icap_multiboot_seq #(
      .SPI_RD_OPCODE (8'h0B),
      .ACK_TIMEOUT   (TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .boot_addr   (boot_addr),
      .golden_addr (golden_addr),
      .cyc_o       (cyc_o),
      .stb_o       (stb_o),
      .we_o        (we_o),
      .dat_o       (dat_o),
      .ack_i       (ack_i),
      .busy        (busy),
      .done        (done),
      .error       (error)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   int          dly [14];
   bit          stray;
   int          inject_word;
   int          abort_word;
   logic [15:0] got [$];
   int          cycles;
   int          stb_total;
   bit          aborted;

   function automatic logic [15:0] model_word(int i, logic [23:0] b, logic [23:0] g);
      logic [15:0] seq [14];
      seq = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, b[15:0], 16'h3281,
              {8'h0B, b[23:16]}, 16'h32A1, g[15:0], 16'h32C1,
              {8'h0B, g[23:16]}, 16'h30A1, 16'h000E, 16'h2000};
      return seq[i];
   endfunction

   function automatic int model_cycles();
      int s = 0;
      for (int i = 0; i < 14; i++) s += dly[i] + 2;
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulses start, then plays a slave that acks dly[w] cycles after the first stb of word w
   // (negative = never); records each word and the cycle count from first stb to done.
   task automatic run_seq(input logic [23:0] b, input logic [23:0] g);
      int          wcnt;
      logic [15:0] cur;
      boot_addr   = b;
      golden_addr = g;
      ack_i       = 1'b0;
      start       = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (stb_o !== 1'b1 || done !== 1'b0 || error !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL accept_edge stb=%b done=%b error=%b busy=%b required 1 0 0 1",
                  stb_o, done, error, busy);
      end
      got.delete();
      cycles    = 1;
      stb_total = 0;
      wcnt      = 0;
      aborted   = 0;
      cur       = 16'h0000;
      for (int t = 0; t < 20000; t++) begin
         start = 1'b0;
         if (stb_o) begin
            if (wcnt == 0) begin
               got.push_back(dat_o[15:0]);
               cur = dat_o[15:0];
            end else begin
               checks++;
               if (dat_o[15:0] !== cur || we_o !== 1'b1 || cyc_o !== 1'b1) begin
                  failures++;
                  $display("FAIL dat_stable word=%0d dat=%h we=%b cyc=%b required %h 1 1",
                           got.size() - 1, dat_o[15:0], we_o, cyc_o, cur);
               end
            end
            wcnt++;
            stb_total++;
            if (abort_word >= 0 && got.size() == abort_word + 1) begin
               #2 reset = 1'b1;
               #1;
               checks++;
               if (cyc_o !== 1'b0 || stb_o !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
                   error !== 1'b0 || dat_o !== 32'h0) begin
                  failures++;
                  $display("FAIL async_reset cyc=%b stb=%b busy=%b done=%b error=%b dat=%h required all 0",
                           cyc_o, stb_o, busy, done, error, dat_o);
               end
               reset   = 1'b0;
               ack_i   = 1'b0;
               aborted = 1;
               break;
            end
            if (inject_word >= 0 && got.size() == inject_word + 1 && wcnt == 1) begin
               start     = 1'b1;
               boot_addr = 24'h123456;
            end
            ack_i = (dly[got.size() - 1] >= 0) && (wcnt == dly[got.size() - 1] + 1);
         end else begin
            wcnt  = 0;
            ack_i = stray && busy;
         end
         if (done || error) break;
         tick();
         cycles++;
      end
      ack_i = 1'b0;
      start = 1'b0;
   endtask

   task automatic set_delays(input int d);
      for (int i = 0; i < 14; i++) dly[i] = d;
      stray       = 0;
      inject_word = -1;
      abort_word  = -1;
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      start       = 1'b0;
      ack_i       = 1'b0;
      boot_addr   = 24'h0;
      golden_addr = 24'h0;
      tick();
      tick();
      checks++;
      if (cyc_o !== 1'b0 || stb_o !== 1'b0 || we_o !== 1'b0 || dat_o !== 32'h0 ||
          busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
         failures++;
         $display("FAIL reset_state cyc=%b stb=%b we=%b dat=%h busy=%b done=%b error=%b required all 0",
                  cyc_o, stb_o, we_o, dat_o, busy, done, error);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_normal();
      logic [23:0] b = 24'h0A0000;
      logic [23:0] g = 24'h000000;
      set_delays(1);
      run_seq(b, g);
      checks++;
      if (got.size() != 14) begin
         failures++;
         $display("FAIL normal_count words=%0d required 14", got.size());
      end
      for (int i = 0; i < 14 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== model_word(i, b, g)) begin
            failures++;
            $display("FAIL normal_word%0d got=%h required %h", i, got[i], model_word(i, b, g));
         end
      end
      checks++;
      if (cycles != 42 || cycles != model_cycles()) begin
         failures++;
         $display("FAIL normal_latency cycles=%0d required 42", cycles);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
         failures++;
         $display("FAIL normal_end done=%b busy=%b error=%b required 1 0 0", done, busy, error);
      end
   endtask

   task automatic test_random();
      logic [23:0] b;
      logic [23:0] g;
      for (int it = 0; it < 5; it++) begin
         set_delays(0);
         for (int i = 0; i < 14; i++) dly[i] = $urandom_range(0, 5);
         stray = 1'($urandom_range(0, 1));
         b = 24'($urandom);
         g = 24'($urandom);
         run_seq(b, g);
         for (int i = 0; i < 14; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== model_word(i, b, g)) begin
               failures++;
               $display("FAIL random%0d_word%0d got=%h required %h", it, i,
                        (i < got.size()) ? got[i] : 16'hxxxx, model_word(i, b, g));
            end
         end
         checks++;
         if (cycles != model_cycles() || done !== 1'b1 || error !== 1'b0) begin
            failures++;
            $display("FAIL random%0d_end cycles=%0d done=%b error=%b required %0d 1 0",
                     it, cycles, done, error, model_cycles());
         end
      end
   endtask

   task automatic test_timeout();
      set_delays(1);
      dly[0] = -1;
      run_seq(24'h0A0000, 24'h0);
      checks++;
      if (got.size() != 1 || stb_total != TMO) begin
         failures++;
         $display("FAIL timeout_len words=%0d stb_cycles=%0d required 1 %0d", got.size(), stb_total, TMO);
      end
      checks++;
      if (error !== 1'b1 || cyc_o !== 1'b0 || stb_o !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL timeout_end error=%b cyc=%b stb=%b busy=%b done=%b required 1 0 0 0 0",
                  error, cyc_o, stb_o, busy, done);
      end
   endtask

   task automatic test_start_while_busy();
      logic [23:0] b = 24'hABCDEF;
      logic [23:0] g = 24'h010203;
      set_delays(1);
      inject_word = 5;
      run_seq(b, g);
      for (int i = 0; i < 14; i++) begin
         checks++;
         if (i >= got.size() || got[i] !== model_word(i, b, g)) begin
            failures++;
            $display("FAIL busy_start_word%0d got=%h required %h", i,
                     (i < got.size()) ? got[i] : 16'hxxxx, model_word(i, b, g));
         end
      end
      checks++;
      if (done !== 1'b1 || cycles != model_cycles()) begin
         failures++;
         $display("FAIL busy_start_end done=%b cycles=%0d required 1 %0d", done, cycles, model_cycles());
      end
   endtask

   task automatic test_reset_mid();
      logic [23:0] b = 24'h55AA33;
      logic [23:0] g = 24'h0F0F0F;
      set_delays(1);
      abort_word = 7;
      run_seq(b, g);
      checks++;
      if (aborted != 1 || got.size() != 8) begin
         failures++;
         $display("FAIL reset_mid_reach aborted=%0d words=%0d required 1 8", aborted, got.size());
      end
      tick();
      checks++;
      if (busy !== 1'b0 || stb_o !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_idle busy=%b stb=%b done=%b required 0 0 0", busy, stb_o, done);
      end
      set_delays(1);
      run_seq(b, g);
      for (int i = 0; i < 14; i++) begin
         checks++;
         if (i >= got.size() || got[i] !== model_word(i, b, g)) begin
            failures++;
            $display("FAIL reset_replay_word%0d got=%h required %h", i,
                     (i < got.size()) ? got[i] : 16'hxxxx, model_word(i, b, g));
         end
      end
   endtask

   task automatic test_restart();
      logic [23:0] b = 24'h224466;
      logic [23:0] g = 24'h775533;
      set_delays(2);
      run_seq(b, g);
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL restart_first done=%b required 1", done);
      end
      set_delays(1);
      run_seq(b, g);
      checks++;
      if (got.size() != 14 || done !== 1'b1 || cycles != model_cycles()) begin
         failures++;
         $display("FAIL restart_from_done words=%0d done=%b cycles=%0d required 14 1 %0d",
                  got.size(), done, cycles, model_cycles());
      end
      set_delays(1);
      dly[3] = -1;
      run_seq(b, g);
      checks++;
      if (error !== 1'b1 || got.size() != 4) begin
         failures++;
         $display("FAIL restart_fault error=%b words=%0d required 1 4", error, got.size());
      end
      set_delays(0);
      run_seq(g, b);
      for (int i = 0; i < 14; i++) begin
         checks++;
         if (i >= got.size() || got[i] !== model_word(i, g, b)) begin
            failures++;
            $display("FAIL restart_from_fault_word%0d got=%h required %h", i,
                     (i < got.size()) ? got[i] : 16'hxxxx, model_word(i, g, b));
         end
      end
      checks++;
      if (done !== 1'b1 || error !== 1'b0) begin
         failures++;
         $display("FAIL restart_from_fault_end done=%b error=%b required 1 0", done, error);
      end
   endtask

   task automatic test_boundary();
      logic [23:0] b = 24'h3C3C3C;
      logic [23:0] g = 24'hC3C3C3;
      set_delays(1);
      dly[13] = TMO - 1;
      stray   = 1;
      run_seq(b, g);
      checks++;
      if (done !== 1'b1 || error !== 1'b0 || got.size() != 14 || cycles != model_cycles()) begin
         failures++;
         $display("FAIL ack_at_timeout done=%b error=%b words=%0d cycles=%0d required 1 0 14 %0d",
                  done, error, got.size(), cycles, model_cycles());
      end
      set_delays(1);
      dly[13] = TMO;
      run_seq(b, g);
      checks++;
      if (done !== 1'b0 || error !== 1'b1 || got.size() != 14) begin
         failures++;
         $display("FAIL ack_after_timeout done=%b error=%b words=%0d required 0 1 14",
                  done, error, got.size());
      end
      reset = 1'b1;
      #2;
      reset = 1'b0;
      tick();
      ack_i = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (busy !== 1'b0 || stb_o !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
         failures++;
         $display("FAIL stray_ack_idle busy=%b stb=%b done=%b error=%b required 0 0 0 0",
                  busy, stb_o, done, error);
      end
      ack_i = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_normal();
      test_random();
      test_timeout();
      test_start_while_busy();
      test_reset_mid();
      test_restart();
      test_boundary();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
